// File: rtl/spad_pkg.sv
// Shared scratchpad definitions: width helpers and per-scratchpad geometry.
package spad_pkg;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) begin
      result = result + 1;
    end
    return result;
  endfunction

  // Number of memory words moved by one transfer of data_w bits.
  function automatic int unsigned words(input int unsigned data_w, input int unsigned mem_w);
    return data_w / mem_w;
  endfunction

  localparam int unsigned SPAD_MEM_WIDTH     = 16;

  localparam int unsigned IFMAP_W_WIDTH      = 16;
  localparam int unsigned IFMAP_R_WIDTH      = 64;
  localparam int unsigned IFMAP_DEPTH        = 16;
  localparam int unsigned IFMAP_ADDR_WIDTH   = clog2(IFMAP_DEPTH);

  localparam int unsigned FILTER_W_WIDTH     = 64;
  localparam int unsigned FILTER_R_WIDTH     = 16;
  localparam int unsigned FILTER_DEPTH       = 256;
  localparam int unsigned FILTER_ADDR_WIDTH  = clog2(FILTER_DEPTH);

  localparam int unsigned PSUM_W_WIDTH       = 16;
  localparam int unsigned PSUM_R_WIDTH       = 16;
  localparam int unsigned PSUM_DEPTH         = 32;
  localparam int unsigned PSUM_ADDR_WIDTH    = clog2(PSUM_DEPTH);

endpackage

// File: rtl/spad_ptr.sv
// Modulo 2**ADDR_WIDTH address pointer advancing by a fixed step; clear wins over enable.
module spad_ptr #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned STEP       = 1
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  en,
  output logic [ADDR_WIDTH-1:0] ptr
);

  // Wrap-around is plain truncation of the sum.
  localparam logic [ADDR_WIDTH-1:0] STEP_C = ADDR_WIDTH'(STEP);

  logic [ADDR_WIDTH-1:0] ptr_q;

  always_ff @(posedge clk) begin
    if (clear) begin
      ptr_q <= '0;
    end else if (en) begin
      ptr_q <= ptr_q + STEP_C;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/spad_fifo_ctrl.sv
// Scratchpad FIFO pointer/flow-control engine: push/pop handshake, memory address drive,
// occupancy and sticky error flags for a negedge-write, combinational-read memory.
module spad_fifo_ctrl
  import spad_pkg::*;
#(
  parameter int unsigned R_DATA_WIDTH = 64,
  parameter int unsigned W_DATA_WIDTH = 16,
  parameter int unsigned MEM_WIDTH    = 16,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned ADDR_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  push_valid,
  output logic                  push_ready,
  output logic                  pop_valid,
  input  logic                  pop_ready,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow_err,
  output logic                  underflow_err
);

  localparam int unsigned W_WORDS   = words(W_DATA_WIDTH, MEM_WIDTH);
  localparam int unsigned R_WORDS   = words(R_DATA_WIDTH, MEM_WIDTH);
  localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;

  localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] W_C     = CNT_WIDTH'(W_WORDS);
  localparam logic [CNT_WIDTH-1:0] R_C     = CNT_WIDTH'(R_WORDS);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CNT_WIDTH-1:0]  count_q;
  logic [CNT_WIDTH-1:0]  count_d;
  logic [CNT_WIDTH-1:0]  space;
  logic                  push_fire;
  logic                  pop_fire;
  logic                  clear;
  logic                  overflow_q;
  logic                  underflow_q;

  // Handshake looks only at registered occupancy; same-cycle traffic never creates room or data.
  assign space      = DEPTH_C - count_q;
  assign push_ready = (space >= W_C);
  assign pop_valid  = (count_q >= R_C);
  assign push_fire  = push_valid & push_ready;
  assign pop_fire   = pop_valid & pop_ready;
  assign clear      = reset | flush;

  spad_ptr #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .STEP       (W_WORDS)
  ) u_wr_ptr (
    .clk   (clk),
    .clear (clear),
    .en    (push_fire),
    .ptr   (wr_ptr)
  );

  spad_ptr #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .STEP       (R_WORDS)
  ) u_rd_ptr (
    .clk   (clk),
    .clear (clear),
    .en    (pop_fire),
    .ptr   (rd_ptr)
  );

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else begin
      if (push_fire) count_d = count_d + W_C;
      if (pop_fire)  count_d = count_d - R_C;
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (!flush) begin
      // Requests in a flush cycle are discarded, so they cannot raise an error either.
      overflow_q  <= overflow_q  | (push_valid & ~push_ready);
      underflow_q <= underflow_q | (pop_ready  & ~pop_valid);
    end
  end

  assign mem_wr_en     = push_fire & ~flush;
  assign mem_wr_addr   = wr_ptr;
  assign mem_rd_en     = pop_valid;
  assign mem_rd_addr   = rd_ptr;
  assign count         = count_q;
  assign full          = (count_q == DEPTH_C);
  assign empty         = (count_q == '0);
  assign overflow_err  = overflow_q;
  assign underflow_err = underflow_q;

`ifndef SYNTHESIS
  // Full is the only case where equal pointers mean FIFO_DEPTH words rather than zero.
  a_count_matches_ptrs: assert property (@(posedge clk) disable iff (reset)
    (count_q <= DEPTH_C) && (count_q[ADDR_WIDTH-1:0] == (wr_ptr - rd_ptr)));
`endif

endmodule

// File: tb/tb_spad_fifo_ctrl.sv
// Randomized scoreboard bench for spad_fifo_ctrl with a queue-based reference model.
module tb_spad_fifo_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance: 16-bit pushes, 64-bit pops.
  logic        reset, flush, push_valid, pop_ready;
  logic        push_ready, pop_valid, mem_wr_en, mem_rd_en, full, empty;
  logic        overflow_err, underflow_err;
  logic [3:0]  mem_wr_addr, mem_rd_addr;
  logic [4:0]  count;
  logic [15:0] push_data;

  // Swapped instance: 64-bit pushes, 16-bit pops.
  logic        reset2, flush2, push_valid2, pop_ready2;
  logic        push_ready2, pop_valid2, mem_wr_en2, mem_rd_en2, full2, empty2;
  logic        overflow_err2, underflow_err2;
  logic [3:0]  mem_wr_addr2, mem_rd_addr2;
  logic [4:0]  count2;
  logic [63:0] push_data2;

  spad_fifo_ctrl u_dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .push_valid    (push_valid),
    .push_ready    (push_ready),
    .pop_valid     (pop_valid),
    .pop_ready     (pop_ready),
    .mem_wr_en     (mem_wr_en),
    .mem_wr_addr   (mem_wr_addr),
    .mem_rd_en     (mem_rd_en),
    .mem_rd_addr   (mem_rd_addr),
    .count         (count),
    .full          (full),
    .empty         (empty),
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err)
  );

  spad_fifo_ctrl #(
    .R_DATA_WIDTH (16),
    .W_DATA_WIDTH (64)
  ) u_dut_swap (
    .clk           (clk),
    .reset         (reset2),
    .flush         (flush2),
    .push_valid    (push_valid2),
    .push_ready    (push_ready2),
    .pop_valid     (pop_valid2),
    .pop_ready     (pop_ready2),
    .mem_wr_en     (mem_wr_en2),
    .mem_wr_addr   (mem_wr_addr2),
    .mem_rd_en     (mem_rd_en2),
    .mem_rd_addr   (mem_rd_addr2),
    .count         (count2),
    .full          (full2),
    .empty         (empty2),
    .overflow_err  (overflow_err2),
    .underflow_err (underflow_err2)
  );

  // Bench-side memories: write on negedge, combinational read.
  logic [15:0] mem  [16];
  logic [15:0] mem2 [16];

  always @(negedge clk) begin
    if (mem_wr_en) mem[mem_wr_addr] <= push_data;
    if (mem_wr_en2) begin
      for (int i = 0; i < 4; i++) mem2[4'(mem_wr_addr2 + 4'(i))] <= push_data2[16*i +: 16];
    end
  end

  function automatic logic [63:0] rd_data();
    logic [63:0] r;
    for (int i = 0; i < 4; i++) r[16*i +: 16] = mem[4'(mem_rd_addr + 4'(i))];
    return r;
  endfunction

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=0x%0h expected=0x%0h", name, $time, act, exp);
    end
  endtask

  typedef struct packed {
    logic [4:0] count;
    logic       full, empty, push_ready, pop_valid, wr_en, rd_en, ovf, unf;
    logic [3:0] wr_addr, rd_addr;
  } exp_t;

  // Reference model: stored words in order, total-words-moved addresses, sticky flags.
  exp_t        exp_q [$];
  logic [63:0] dq [$];
  logic [15:0] mq [$];
  int          m_wr = 0;
  int          m_rd = 0;
  bit          m_ovf = 0;
  bit          m_unf = 0;

  task automatic step(input bit rst, input bit fl, input bit pv, input bit pr,
                      input logic [15:0] d);
    exp_t        e;
    bit          pf, qf;
    logic [15:0] tmp;
    @(posedge clk);
    #1;
    reset = rst; flush = fl; push_valid = pv; pop_ready = pr; push_data = d;
    e.count      = 5'(mq.size());
    e.full       = (mq.size() == 16);
    e.empty      = (mq.size() == 0);
    e.push_ready = (16 - mq.size()) >= 1;
    e.pop_valid  = (mq.size() >= 4);
    pf           = pv && e.push_ready;
    qf           = pr && e.pop_valid;
    e.wr_en      = pf && !fl;
    e.rd_en      = e.pop_valid;
    e.wr_addr    = 4'(m_wr);
    e.rd_addr    = 4'(m_rd);
    e.ovf        = m_ovf;
    e.unf        = m_unf;
    exp_q.push_back(e);
    if (qf) dq.push_back({mq[3], mq[2], mq[1], mq[0]});
    if (rst || fl) begin
      mq.delete();
      m_wr = 0;
      m_rd = 0;
      if (rst) begin
        m_ovf = 0;
        m_unf = 0;
      end
    end else begin
      if (pv && !e.push_ready) m_ovf = 1;
      if (pr && !e.pop_valid)  m_unf = 1;
      if (qf) begin
        for (int i = 0; i < 4; i++) tmp = mq.pop_front();
        m_rd = (m_rd + 4) % 16;
      end
      if (pf) begin
        mq.push_back(d);
        m_wr = (m_wr + 1) % 16;
      end
    end
  endtask

  exp_t mon_e;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("count",         64'(count),         64'(mon_e.count));
      chk("full",          64'(full),          64'(mon_e.full));
      chk("empty",         64'(empty),         64'(mon_e.empty));
      chk("push_ready",    64'(push_ready),    64'(mon_e.push_ready));
      chk("pop_valid",     64'(pop_valid),     64'(mon_e.pop_valid));
      chk("mem_wr_en",     64'(mem_wr_en),     64'(mon_e.wr_en));
      chk("mem_wr_addr",   64'(mem_wr_addr),   64'(mon_e.wr_addr));
      chk("mem_rd_en",     64'(mem_rd_en),     64'(mon_e.rd_en));
      chk("mem_rd_addr",   64'(mem_rd_addr),   64'(mon_e.rd_addr));
      chk("overflow_err",  64'(overflow_err),  64'(mon_e.ovf));
      chk("underflow_err", 64'(underflow_err), 64'(mon_e.unf));
      if (pop_valid && pop_ready) begin
        if (dq.size() == 0) chk("pop_data_expected", 64'(dq.size()), 64'd1);
        else                chk("pop_data", rd_data(), dq.pop_front());
      end
    end
  end

  logic [15:0] dq2 [$];

  always @(negedge clk) begin
    if (pop_valid2 && pop_ready2) begin
      if (dq2.size() == 0) chk("swap_data_expected", 64'(dq2.size()), 64'd1);
      else                 chk("swap_pop_data", 64'(mem2[mem_rd_addr2]), 64'(dq2.pop_front()));
    end
  end

  initial begin
    reset = 1'b1; flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0; push_data = '0;
    reset2 = 1'b1; flush2 = 1'b0; push_valid2 = 1'b0; pop_ready2 = 1'b0; push_data2 = '0;
    repeat (2) @(posedge clk);

    // First group assembles only once the fourth word lands.
    for (int i = 1; i <= 4; i++) step(0, 0, 1, 0, 16'(i));
    step(0, 0, 0, 1, 16'h0);

    // Fill to full, then one rejected push.
    for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 16'(16'h100 + i));
    step(0, 0, 1, 0, 16'hdead);
    step(0, 0, 0, 0, 16'h0);
    step(1, 0, 0, 0, 16'h0);

    // Wrap-around of both pointers.
    for (int i = 0; i < 14; i++) step(0, 0, 1, 0, 16'(i));
    for (int i = 0; i < 3; i++)  step(0, 0, 0, 1, 16'h0);
    for (int i = 14; i < 20; i++) step(0, 0, 1, 0, 16'(i));
    step(0, 0, 0, 1, 16'h0);
    step(0, 0, 0, 1, 16'h0);

    // Simultaneous push and pop at count 8.
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 16'(16'h200 + i));
    step(0, 0, 1, 1, 16'h2ff);
    step(0, 0, 0, 1, 16'h0);
    step(0, 0, 1, 0, 16'h300);

    // Underflow at count 2, flush with a push pending, then reset clears the flag.
    step(0, 0, 0, 1, 16'h0);
    step(0, 1, 1, 0, 16'hbeef);
    step(0, 0, 0, 0, 16'h0);
    step(1, 0, 0, 0, 16'h0);
    step(0, 0, 0, 0, 16'h0);

    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 9) < 6), ($urandom_range(0, 1) == 1), 16'($urandom));
    end
    step(0, 0, 0, 0, 16'h0);
    @(negedge clk);
    chk("data_queue_drained", 64'(dq.size()), 64'd0);

    // Swapped widths: one wide push, four narrow pops.
    @(posedge clk);
    #1 reset2 = 1'b0;
    @(posedge clk);
    #1 push_valid2 = 1'b1; push_data2 = 64'hdddd_cccc_bbbb_aaaa;
    @(posedge clk);
    #1 push_valid2 = 1'b0;
    @(negedge clk);
    chk("swap_count", 64'(count2), 64'd4);
    chk("swap_pop_valid", 64'(pop_valid2), 64'd1);
    dq2.push_back(16'haaaa);
    dq2.push_back(16'hbbbb);
    dq2.push_back(16'hcccc);
    dq2.push_back(16'hdddd);
    @(posedge clk);
    #1 pop_ready2 = 1'b1;
    repeat (4) @(posedge clk);
    #1 pop_ready2 = 1'b0;
    @(negedge clk);
    chk("swap_empty", 64'(empty2), 64'd1);
    chk("swap_count_zero", 64'(count2), 64'd0);
    chk("swap_pops_seen", 64'(dq2.size()), 64'd0);
    chk("swap_underflow", 64'(underflow_err2), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
